// File: rtl/uart_rx_frame_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_pkg : receiver state encoding and frame-format defaults
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_rx_frame_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame_if : received-byte valid/ready holding register plus error pulses
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_frame_if
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sync : multi-flop synchroniser for the serial rx pin, resets to idle (1)
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame : 8N1 UART receiver, oversampled, with valid/ready byte output
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_rxclk_en,
    input  wire logic        i_rx,
    uart_rx_frame_if.master  bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 rx_s;
    logic                 byte_done;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (i_rxclk_en) begin
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nxt = ST_START;
                        tick_nxt  = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == HALF_TICK) begin
                        // A start bit that is high again by mid-bit is treated as noise.
                        state_nxt = rx_s ? ST_IDLE : ST_DATA;
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    tick_nxt = tick_cnt + 1'b1;
                    if (tick_cnt == LAST_TICK) begin
                        shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = ST_STOP;
                            tick_nxt  = '0;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick_cnt == LAST_TICK) begin
                        byte_done = rx_s;
                        stop_bad  = !rx_s;
                        state_nxt = rx_s ? ST_IDLE : ST_BREAK;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            // A byte finishing while the old one is being accepted replaces it seamlessly.
            if (byte_done) begin
                if (valid && !bus.ready) begin
                    overrun <= 1'b1;
                end else begin
                    data  <= shift;
                    valid <= 1'b1;
                end
            end else if (valid && bus.ready) begin
                valid <= 1'b0;
            end
        end
    end

    assign bus.data      = data;
    assign bus.valid     = valid;
    assign bus.frame_err = frame_err;
    assign bus.overrun   = overrun;
endmodule
`default_nettype wire
